muldiv_out: RTL and testbench

Result post-processing stage of the M-extension multiply/divide unit, at the opposite end of the datapath from the operand-conditioning stage. It latches the operation context when an operation starts, then waits for the unsigned iterative core to finish. It applies two's-complement sign correction, selects the architectural word, and holds the result under a valid/ready handshake to writeback. With shortcuts compiled in, it resolves trivial operand cases directly from the operand status flags and aborts the core.

---
 rtl/muldiv_out.sv | 230 +++++++++++++++++++++++
 tb/tb_muldiv_out.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_out.sv
// muldiv_out: result post-processing stage of the M-extension multiply/divide unit.
// Latches the operation context at start, waits for the unsigned iterative core,
// applies two's-complement sign correction, selects the architectural word, and
// holds the result under a valid/ready handshake towards writeback.
// Optional feature macro: MULDIV_SHORTCUT_EN resolves trivial operand cases
// (zero, one, minus one) straight from the operand status flags and aborts the core.
module muldiv_out (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    input  logic        muldiv_sel_i,
    input  logic        op_div0_i,
    input  logic        op_div1_i,
    input  logic [1:0]  op_mul_i,
    input  logic [31:0] in_a_i,
    input  logic [31:0] in_b_i,
    input  logic [5:0]  ab_status_i,
    input  logic        core_done_i,
    input  logic [31:0] core_hi_i,
    input  logic [31:0] core_lo_i,
    output logic        core_abort_o,
    output logic        busy_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    input  logic        result_ready_i
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned PLEN = 2 * XLEN;
    localparam int unsigned SLEN = 6;

    // Operand status flag positions: {Bm1, B1, B0, Am1, A1, A0}
    localparam int unsigned ST_A0  = 0;
    localparam int unsigned ST_B0  = 3;
    localparam int unsigned ST_B1  = 4;
    localparam int unsigned ST_BM1 = 5;

    localparam logic [1:0] MUL_LO   = 2'b00;
    localparam logic [1:0] MUL_HSS  = 2'b01;
    localparam logic [1:0] MUL_HSU  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FIX  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    typedef struct packed {
        logic            muldiv_sel;
        logic            div_signed;
        logic            div_rem;
        logic [1:0]      mul_op;
        logic            a_neg;
        logic            b_neg;
        logic [SLEN-1:0] status;
        logic [XLEN-1:0] a;
    } ctx_t;

    state_t          state_q, state_d;
    ctx_t            ctx_q, ctx_d;
    logic [PLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;
    logic            abort_q, abort_d;
    logic            busy_q, busy_d;

    logic            sc_hit;
    logic [XLEN-1:0] sc_res;
    logic [XLEN-1:0] fix_res;
    logic            mul_neg;
    logic [PLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    // Raw operand bits and latched context kept for visibility but not consumed by the datapath
    logic unused_bits;
    assign unused_bits = ^{ab_status_i, in_b_i[XLEN-2:0], ctx_q.status, ctx_q.a};

`ifdef MULDIV_SHORTCUT_EN
    // Trivial-operand detection straight from the conditioning-stage flags; first match wins
    always_comb begin
        sc_hit = 1'b0;
        sc_res = '0;
        if (muldiv_sel_i) begin
            if (ab_status_i[ST_B0]) begin
                sc_hit = 1'b1;
                sc_res = op_div1_i ? in_a_i : '1;
            end else if (ab_status_i[ST_A0]) begin
                sc_hit = 1'b1;
                sc_res = '0;
            end else if (ab_status_i[ST_B1]) begin
                sc_hit = 1'b1;
                sc_res = op_div1_i ? '0 : in_a_i;
            end else if (ab_status_i[ST_BM1] && op_div0_i) begin
                // 0x80000000 / -1 wraps back to 0x80000000 through the negation
                sc_hit = 1'b1;
                sc_res = op_div1_i ? '0 : XLEN'((~in_a_i) + XLEN'(1));
            end
        end else begin
            if (ab_status_i[ST_A0] || ab_status_i[ST_B0]) begin
                sc_hit = 1'b1;
                sc_res = '0;
            end
        end
    end
`else
    // Shortcuts compiled out: every operation runs through the core
    always_comb begin
        sc_hit = 1'b0;
        sc_res = '0;
    end
`endif

    // Sign correction and word selection of the captured core result
    always_comb begin
        mul_neg  = 1'b0;
        prod_fix = prod_q;
        quo_fix  = prod_q[XLEN-1:0];
        rem_fix  = prod_q[PLEN-1:XLEN];
        fix_res  = '0;
        if (ctx_q.muldiv_sel) begin
            if (ctx_q.div_signed && (ctx_q.a_neg ^ ctx_q.b_neg)) begin
                quo_fix = XLEN'((~prod_q[XLEN-1:0]) + XLEN'(1));
            end
            if (ctx_q.div_signed && ctx_q.a_neg) begin
                rem_fix = XLEN'((~prod_q[PLEN-1:XLEN]) + XLEN'(1));
            end
            fix_res = ctx_q.div_rem ? rem_fix : quo_fix;
        end else begin
            case (ctx_q.mul_op)
                MUL_LO, MUL_HSS: mul_neg = ctx_q.a_neg ^ ctx_q.b_neg;
                MUL_HSU:         mul_neg = ctx_q.a_neg;
                default:         mul_neg = 1'b0;
            endcase
            if (mul_neg) begin
                prod_fix = PLEN'((~prod_q) + PLEN'(1));
            end
            fix_res = (ctx_q.mul_op == MUL_LO) ? prod_fix[XLEN-1:0] : prod_fix[PLEN-1:XLEN];
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        ctx_d    = ctx_q;
        prod_d   = prod_q;
        result_d = result_q;
        valid_d  = valid_q;
        abort_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ctx_d.muldiv_sel = muldiv_sel_i;
                    ctx_d.div_signed = op_div0_i;
                    ctx_d.div_rem    = op_div1_i;
                    ctx_d.mul_op     = op_mul_i;
                    ctx_d.a_neg      = in_a_i[XLEN-1];
                    ctx_d.b_neg      = in_b_i[XLEN-1];
                    ctx_d.status     = ab_status_i;
                    ctx_d.a          = in_a_i;
                    if (sc_hit) begin
                        result_d = sc_res;
                        valid_d  = 1'b1;
                        abort_d  = 1'b1;
                        state_d  = S_HOLD;
                    end else begin
                        state_d  = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (core_done_i) begin
                    prod_d  = {core_hi_i, core_lo_i};
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d = fix_res;
                valid_d  = 1'b1;
                state_d  = S_HOLD;
            end
            S_HOLD: begin
                if (result_ready_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Context, core capture and registered outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ctx_q    <= '0;
            prod_q   <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
            abort_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ctx_q    <= ctx_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            abort_q  <= abort_d;
            busy_q   <= busy_d;
        end
    end

    assign result_o       = result_q;
    assign result_valid_o = valid_q;
    assign core_abort_o   = abort_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_muldiv_out.sv
// Bench for muldiv_out: table of operations with golden results, a small model of
// the unsigned core feeding core_hi/core_lo, and a result scoreboard queue.
`timescale 1ns/1ps
module tb_muldiv_out;

`ifdef MULDIV_SHORTCUT_EN
    localparam bit SC_EN = 1'b1;
`else
    localparam bit SC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic        muldiv_sel_i;
    logic        op_div0_i;
    logic        op_div1_i;
    logic [1:0]  op_mul_i;
    logic [31:0] in_a_i;
    logic [31:0] in_b_i;
    logic [5:0]  ab_status_i;
    logic        core_done_i;
    logic [31:0] core_hi_i;
    logic [31:0] core_lo_i;
    logic        core_abort_o;
    logic        busy_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i;

    muldiv_out dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .muldiv_sel_i   (muldiv_sel_i),
        .op_div0_i      (op_div0_i),
        .op_div1_i      (op_div1_i),
        .op_mul_i       (op_mul_i),
        .in_a_i         (in_a_i),
        .in_b_i         (in_b_i),
        .ab_status_i    (ab_status_i),
        .core_done_i    (core_done_i),
        .core_hi_i      (core_hi_i),
        .core_lo_i      (core_lo_i),
        .core_abort_o   (core_abort_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        div0;
        logic        div1;
        logic [1:0]  mul;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_q[$];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic sel, input logic div0, input logic div1,
                                input logic [1:0] mul, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] exp);
        vec_t v;
        v.sel = sel; v.div0 = div0; v.div1 = div1; v.mul = mul;
        v.a = a; v.b = b; v.exp = exp;
        return v;
    endfunction

    function automatic logic [5:0] status(input logic [31:0] a, input logic [31:0] b);
        return {b == 32'hFFFFFFFF, b == 32'd1, b == 32'd0,
                a == 32'hFFFFFFFF, a == 32'd1, a == 32'd0};
    endfunction

    // Architectural RISC-V M-extension result
    function automatic logic [31:0] golden(input vec_t v);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb;
        if (!v.sel) begin
            ea = (v.mul != 2'b11) ? {{32{v.a[31]}}, v.a} : {32'b0, v.a};
            eb = (v.mul[1] == 1'b0) ? {{32{v.b[31]}}, v.b} : {32'b0, v.b};
            p  = ea * eb;
            return (v.mul == 2'b00) ? p[31:0] : p[63:32];
        end
        if (v.b == 32'd0) return v.div1 ? v.a : 32'hFFFFFFFF;
        if (!v.div0) return v.div1 ? (v.a % v.b) : (v.a / v.b);
        if (v.a == 32'h80000000 && v.b == 32'hFFFFFFFF) return v.div1 ? 32'd0 : v.a;
        sa = v.a;
        sb = v.b;
        return v.div1 ? 32'(sa % sb) : 32'(sa / sb);
    endfunction

    // Unsigned core fed with operand magnitudes: {hi, lo} = product or {rem, quo}
    function automatic logic [63:0] core_data(input vec_t v);
        logic        an, bn;
        logic [31:0] ma, mb;
        if (!v.sel) begin
            an = (v.mul != 2'b11) && v.a[31];
            bn = (v.mul[1] == 1'b0) && v.b[31];
        end else begin
            an = v.div0 && v.a[31];
            bn = v.div0 && v.b[31];
        end
        ma = an ? (~v.a + 32'd1) : v.a;
        mb = bn ? (~v.b + 32'd1) : v.b;
        if (!v.sel) return {32'b0, ma} * {32'b0, mb};
        if (mb == 32'd0) return {ma, 32'hFFFFFFFF};
        return {ma % mb, ma / mb};
    endfunction

    function automatic bit takes_shortcut(input vec_t v);
        if (!v.sel) return SC_EN && (v.a == 32'd0 || v.b == 32'd0);
        return SC_EN && (v.b == 32'd0 || v.a == 32'd0 || v.b == 32'd1 ||
                         (v.div0 && v.b == 32'hFFFFFFFF));
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive_op(input vec_t v);
        muldiv_sel_i = v.sel;
        op_div0_i    = v.div0;
        op_div1_i    = v.div1;
        op_mul_i     = v.mul;
        in_a_i       = v.a;
        in_b_i       = v.b;
        ab_status_i  = status(v.a, v.b);
        start_i      = 1'b1;
    endtask

    task automatic scramble_inputs();
        muldiv_sel_i = 1'($urandom);
        op_div0_i    = 1'($urandom);
        op_div1_i    = 1'($urandom);
        op_mul_i     = 2'($urandom);
        in_a_i       = $urandom;
        in_b_i       = $urandom;
        ab_status_i  = 6'($urandom);
    endtask

    // One full operation: start, optional core completion, hold, handshake
    task automatic run_op(input vec_t v);
        bit          sc;
        logic [63:0] cd;
        logic [31:0] held, exp;
        int          dly, hw;
        sc = takes_shortcut(v);
        cd = core_data(v);
        sb_q.push_back(v.exp);
        drive_op(v);
        @(posedge clk); #1;
        start_i = 1'b0;
        scramble_inputs();
        chk("busy_after_start", 32'(busy_o), 32'd1);
        if (sc) begin
            chk("abort_shortcut", 32'(core_abort_o), 32'd1);
            chk("valid_shortcut", 32'(result_valid_o), 32'd1);
        end else begin
            chk("abort_core_path", 32'(core_abort_o), 32'd0);
            chk("valid_wait", 32'(result_valid_o), 32'd0);
            dly = $urandom_range(0, 3);
            repeat (dly) begin
                @(posedge clk); #1;
            end
            core_done_i = 1'b1;
            core_hi_i   = cd[63:32];
            core_lo_i   = cd[31:0];
            @(posedge clk); #1;
            core_done_i = 1'b0;
            core_hi_i   = $urandom;
            core_lo_i   = $urandom;
            chk("valid_fix", 32'(result_valid_o), 32'd0);
            @(posedge clk); #1;
            chk("valid_core_done_plus2", 32'(result_valid_o), 32'd1);
        end
        held = result_o;
        hw   = $urandom_range(1, 3);
        repeat (hw) begin
            core_done_i = 1'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(result_valid_o), 32'd1);
            chk("hold_stable", result_o, held);
            chk("abort_single_pulse", 32'(core_abort_o), 32'd0);
        end
        core_done_i    = 1'b0;
        result_ready_i = 1'b1;
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk("result", result_o, exp);
        end
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        chk("valid_after_xfer", 32'(result_valid_o), 32'd0);
        chk("busy_after_xfer", 32'(busy_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset_i        = 1'b1;
        start_i        = 1'b0;
        muldiv_sel_i   = 1'b0;
        op_div0_i      = 1'b0;
        op_div1_i      = 1'b0;
        op_mul_i       = 2'b00;
        in_a_i         = '0;
        in_b_i         = '0;
        ab_status_i    = '0;
        core_done_i    = 1'b0;
        core_hi_i      = '0;
        core_lo_i      = '0;
        result_ready_i = 1'b0;

        // Directed vectors (sel, div0, div1, mul, a, b, expected)
        vecs.push_back(mk(0, 0, 0, 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA));
        vecs.push_back(mk(0, 0, 0, 2'b01, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF));
        vecs.push_back(mk(0, 0, 0, 2'b11, 32'h80000000, 32'd4, 32'h00000002));
        vecs.push_back(mk(0, 0, 0, 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 1, 1, 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 1, 0, 2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD));
        vecs.push_back(mk(1, 0, 0, 2'b00, 32'h00001234, 32'd0, 32'hFFFFFFFF));
        vecs.push_back(mk(1, 0, 1, 2'b00, 32'h00001234, 32'd0, 32'h00001234));
        vecs.push_back(mk(1, 1, 0, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000));
        vecs.push_back(mk(1, 1, 1, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h00000000));
        vecs.push_back(mk(0, 0, 0, 2'b01, 32'h00000000, 32'd5, 32'h00000000));
        vecs.push_back(mk(1, 1, 0, 2'b00, 32'hFFFFFFF9, 32'd1, 32'hFFFFFFF9));
        vecs.push_back(mk(1, 0, 1, 2'b00, 32'd7, 32'd1, 32'd0));
        vecs.push_back(mk(1, 0, 0, 2'b00, 32'd0, 32'd5, 32'd0));
        vecs.push_back(mk(1, 0, 0, 2'b00, 32'd100, 32'hFFFFFFFF, 32'd0));
        vecs.push_back(mk(1, 1, 0, 2'b00, 32'd9, 32'hFFFFFFFF, 32'hFFFFFFF7));
        for (int i = 0; i < 24; i++) begin
            v.sel  = 1'($urandom);
            v.div0 = v.sel & 1'($urandom);
            v.div1 = v.sel & 1'($urandom);
            v.mul  = v.sel ? 2'b00 : 2'($urandom);
            v.a    = pick();
            v.b    = pick();
            if (v.sel && v.div0 && v.b == 32'd0) v.a[31] = 1'b0;
            v.exp  = golden(v);
            vecs.push_back(v);
        end

        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        chk("reset_result", result_o, 32'd0);
        chk("reset_valid", 32'(result_valid_o), 32'd0);
        chk("reset_abort", 32'(core_abort_o), 32'd0);
        chk("reset_busy", 32'(busy_o), 32'd0);

        // Stray core_done in IDLE is ignored
        core_done_i = 1'b1;
        core_hi_i   = 32'hDEADBEEF;
        core_lo_i   = 32'hCAFEF00D;
        @(posedge clk); #1;
        core_done_i = 1'b0;
        chk("idle_done_valid", 32'(result_valid_o), 32'd0);
        chk("idle_done_busy", 32'(busy_o), 32'd0);

        // Reset during WAIT abandons the op silently
        drive_op(mk(0, 0, 0, 2'b00, 32'd6, 32'd7, 32'd42));
        @(posedge clk); #1;
        start_i = 1'b0;
        @(posedge clk); #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk("wait_reset_busy", 32'(busy_o), 32'd0);
        chk("wait_reset_valid", 32'(result_valid_o), 32'd0);
        chk("wait_reset_abort", 32'(core_abort_o), 32'd0);

        // Long HOLD with ignored start, then reset mid-HOLD
        v = mk(0, 0, 0, 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA);
        drive_op(v);
        @(posedge clk); #1;
        start_i     = 1'b0;
        core_done_i = 1'b1;
        core_hi_i   = 32'd0;
        core_lo_i   = 32'd6;
        @(posedge clk); #1;
        core_done_i = 1'b0;
        @(posedge clk); #1;
        chk("long_hold_valid", 32'(result_valid_o), 32'd1);
        chk("long_hold_result", result_o, 32'hFFFFFFFA);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) drive_op(mk(0, 0, 0, 2'b00, 32'd0, 32'd0, 32'd0));
            @(posedge clk); #1;
            start_i = 1'b0;
            chk("long_hold_stable", result_o, 32'hFFFFFFFA);
            chk("long_hold_valid_kept", 32'(result_valid_o), 32'd1);
            chk("long_hold_no_abort", 32'(core_abort_o), 32'd0);
        end
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        chk("hold_reset_valid", 32'(result_valid_o), 32'd0);
        chk("hold_reset_busy", 32'(busy_o), 32'd0);
        chk("hold_reset_result", result_o, 32'd0);

        // Table-driven operations through the scoreboard
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i]);
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
